snax_alu_job_sched: RTL and testbench

// Job scheduler in front of the SNAX ALU PE array. Buffers up to QueueDepth
// {op, len} jobs from the CSR manager and dispatches them one at a time.

---
 rtl/snax_alu_job_sched.sv | 162 ++++++++++++++++
 tb/tb_snax_alu_job_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_alu_job_sched.sv
// Job scheduler for the SNAX ALU PE array: queues {op, len} jobs, runs them one at a time
// and keeps per-job beat and cycle accounting. Optional IRQ ports under SNAX_ALU_SCHED_IRQ_EN.
module snax_alu_job_sched #(
    parameter int QueueDepth = 4,
    parameter int LenWidth   = 32,
    parameter int PerfWidth  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [1:0]                    job_op_i,
    input  logic [LenWidth-1:0]           job_len_i,
    input  logic                          job_valid_i,
    output logic                          job_ready_o,
    output logic [1:0]                    alu_config_o,
    output logic                          alu_in_ready_o,
    input  logic                          alu_in_fire_i,
    input  logic                          alu_out_fire_i,
    output logic                          busy_o,
    output logic [$clog2(QueueDepth):0]   queue_level_o,
    output logic [PerfWidth-1:0]          jobs_done_o,
    output logic [PerfWidth-1:0]          last_cycles_o,
    output logic                          spurious_o
`ifdef SNAX_ALU_SCHED_IRQ_EN
    ,
    output logic                          irq_o,
    input  logic                          irq_clr_i
`endif
);

    // state | meaning
    // IDLE  | no job running; pops the queue head whenever one is waiting
    // RUN   | job active, input beats still owed to the PEs
    // DRAIN | all inputs taken, waiting for the remaining output beats
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int PtrWidth = $clog2(QueueDepth);
    localparam int LvlWidth = PtrWidth + 1;

    logic [1:0]          op_mem  [QueueDepth];
    logic [LenWidth-1:0] len_mem [QueueDepth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [LvlWidth-1:0] level, level_next;
    logic                full, empty, push, pop;
    logic [1:0]          head_op;
    logic [LenWidth-1:0] head_len;

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [LenWidth-1:0]  len_q, in_cnt, out_cnt;
    logic [PerfWidth-1:0] cyc, jobs_done, last_cycles;
    logic                 spurious, busy, in_acc, out_ok, out_acc, spur;
    logic                 complete, zero_done;

    assign full       = (level == LvlWidth'(QueueDepth));
    assign empty      = (level == '0);
    assign push       = job_valid_i && !full;
    assign head_op    = op_mem[rd_ptr];
    assign head_len   = len_mem[rd_ptr];
    assign level_next = level + LvlWidth'(push) - LvlWidth'(pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            op_mem[wr_ptr]  <= job_op_i;
            len_mem[wr_ptr] <= job_len_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            level <= level_next;
        end
    end

    assign busy    = (state_q != IDLE);
    assign in_acc  = (state_q == RUN) && alu_in_fire_i && (in_cnt < len_q);
    assign out_ok  = busy && (out_cnt != len_q);
    assign out_acc = out_ok && alu_out_fire_i;
    assign spur    = alu_out_fire_i && !out_ok;

    // A completing job hands over to the queue head in the same cycle, so
    // back-to-back jobs run without an IDLE bubble.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        complete  = 1'b0;
        zero_done = 1'b0;
        case (state_q)
            IDLE:    pop = !empty;
            RUN:     if (in_acc && (in_cnt + LenWidth'(1) == len_q)) state_d = DRAIN;
            default: ;
        endcase
        if (out_acc && (out_cnt + LenWidth'(1) == len_q)) begin
            complete = 1'b1;
            state_d  = IDLE;
            pop      = !empty;
        end
        if (pop) begin
            if (head_len == '0) zero_done = 1'b1;
            else                state_d   = RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= '0;
            len_q       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            cyc         <= '0;
            jobs_done   <= '0;
            last_cycles <= '0;
            spurious    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                op_q    <= head_op;
                len_q   <= head_len;
                in_cnt  <= '0;
                out_cnt <= '0;
                cyc     <= '0;
            end else begin
                if (in_acc)  in_cnt  <= in_cnt + LenWidth'(1);
                if (out_acc) out_cnt <= out_cnt + LenWidth'(1);
                if (busy)    cyc     <= cyc + PerfWidth'(1);
            end
            if (complete || zero_done)
                jobs_done <= jobs_done + PerfWidth'(complete) + PerfWidth'(zero_done);
            if (zero_done)     last_cycles <= '0;
            else if (complete) last_cycles <= cyc + PerfWidth'(1);
            if (spur) spurious <= 1'b1;
        end
    end

`ifdef SNAX_ALU_SCHED_IRQ_EN
    logic irq, irq_set;
    assign irq_set = (complete || zero_done) && (state_d == IDLE) && (level_next == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        irq <= 1'b0;
        else if (irq_set)   irq <= 1'b1;
        else if (irq_clr_i) irq <= 1'b0;
    end
    assign irq_o = irq;
`endif

    assign job_ready_o    = !full;
    assign alu_config_o   = op_q;
    assign alu_in_ready_o = (state_q == RUN) && (in_cnt < len_q);
    assign busy_o         = busy;
    assign queue_level_o  = level;
    assign jobs_done_o    = jobs_done;
    assign last_cycles_o  = last_cycles;
    assign spurious_o     = spurious;

endmodule

// File: tb/tb_snax_alu_job_sched.sv
// Bench for snax_alu_job_sched: directed scenarios plus random traffic, every cycle
// compared against a job-queue reference model.
module tb_snax_alu_job_sched;
    localparam int QD = 4;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] len;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  job_op = '0;
    logic [31:0] job_len = '0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  alu_config;
    logic        alu_in_ready;
    logic        in_fire = 1'b0;
    logic        out_fire = 1'b0;
    logic        busy;
    logic [2:0]  queue_level;
    logic [31:0] jobs_done, last_cycles;
    logic        spurious;
    logic        irq_clr = 1'b0;
`ifdef SNAX_ALU_SCHED_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    snax_alu_job_sched #(.QueueDepth(QD), .LenWidth(32), .PerfWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_op_i(job_op), .job_len_i(job_len), .job_valid_i(job_valid),
        .job_ready_o(job_ready), .alu_config_o(alu_config),
        .alu_in_ready_o(alu_in_ready), .alu_in_fire_i(in_fire),
        .alu_out_fire_i(out_fire), .busy_o(busy), .queue_level_o(queue_level),
        .jobs_done_o(jobs_done), .last_cycles_o(last_cycles), .spurious_o(spurious)
`ifdef SNAX_ALU_SCHED_IRQ_EN
        , .irq_o(irq), .irq_clr_i(irq_clr)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    // reference model: job queue plus the running job's beat/cycle accounting
    job_t        jq[$];
    bit          m_run, m_spur, m_irq, m_fin;
    logic [1:0]  m_op;
    logic [31:0] m_len, m_ins, m_outs, m_cyc, m_done, m_last;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("job_ready", 64'(job_ready), 64'(jq.size() < QD));
        chk("queue_level", 64'(queue_level), 64'(jq.size()));
        chk("busy", 64'(busy), 64'(m_run));
        chk("in_ready", 64'(alu_in_ready), 64'(m_run && (m_ins < m_len)));
        chk("alu_config", 64'(alu_config), 64'(m_op));
        chk("jobs_done", 64'(jobs_done), 64'(m_done));
        chk("last_cycles", 64'(last_cycles), 64'(m_last));
        chk("spurious", 64'(spurious), 64'(m_spur));
`ifdef SNAX_ALU_SCHED_IRQ_EN
        chk("irq", 64'(irq), 64'(m_irq));
`endif
    endtask

    task automatic model_reset();
        jq.delete();
        m_run = 0; m_spur = 0; m_irq = 0; m_fin = 0;
        m_op = '0; m_len = '0; m_ins = '0; m_outs = '0;
        m_cyc = '0; m_done = '0; m_last = '0;
    endtask

    task automatic start_job(job_t j);
        m_op = j.op; m_len = j.len;
        m_ins = '0; m_outs = '0; m_cyc = '0;
        if (j.len == 0) begin
            m_done++; m_last = '0; m_fin = 1;
        end else begin
            m_run = 1;
        end
    endtask

    task automatic model_update(bit pv, logic [1:0] op, logic [31:0] len, bit fi, bit fo, bit clr);
        int   sz = jq.size();
        job_t j;
        m_fin = 0;
        if (!m_run) begin
            if (fo) m_spur = 1;
            if (sz > 0) begin j = jq.pop_front(); start_job(j); end
        end else begin
            if (fi && m_ins < m_len) m_ins++;
            if (fo) begin
                if (m_outs < m_len) m_outs++;
                else m_spur = 1;
            end
            if (m_outs == m_len) begin
                m_done++; m_last = m_cyc + 1; m_run = 0; m_fin = 1;
                if (sz > 0) begin j = jq.pop_front(); start_job(j); end
            end else begin
                m_cyc++;
            end
        end
        if (pv && sz < QD) jq.push_back('{op: op, len: len});
        if (m_fin && !m_run && jq.size() == 0) m_irq = 1;
        else if (clr) m_irq = 0;
    endtask

    task automatic step(bit pv, logic [1:0] op, logic [31:0] len, bit fi, bit fo, bit clr);
        job_valid = pv; job_op = op; job_len = len;
        in_fire = fi; out_fire = fo; irq_clr = clr;
        @(negedge clk);
        check_all();
        model_update(pv, op, len, fi, fo, clr);
        @(posedge clk);
        #1;
        job_valid = 0; in_fire = 0; out_fire = 0; irq_clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        chk("rst_level", 64'(queue_level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(alu_in_ready), 64'd0);
        chk("rst_config", 64'(alu_config), 64'd0);
        chk("rst_done", 64'(jobs_done), 64'd0);
        chk("rst_last", 64'(last_cycles), 64'd0);
        chk("rst_spurious", 64'(spurious), 64'd0);
`ifdef SNAX_ALU_SCHED_IRQ_EN
        chk("rst_irq", 64'(irq), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(bit allow_push, bit rnd);
        bit fi, fo, pv, clr;
        fi  = m_run && (m_ins < m_len) && (!rnd || $urandom_range(0, 3) != 0);
        if (rnd && $urandom_range(0, 7) == 0) fi = 1;
        fo  = m_run && (m_outs < m_ins) && (!rnd || $urandom_range(0, 2) != 0);
        pv  = allow_push && ($urandom_range(0, 2) == 0);
        clr = rnd && ($urandom_range(0, 3) == 0);
        step(pv, 2'($urandom_range(0, 3)), 32'($urandom_range(1, 5)), fi, fo, clr);
    endtask

    task automatic run_jobs(logic [31:0] target, int budget);
        int n = 0;
        while (m_done < target && n < budget) begin rand_step(0, 0); n++; end
        if (m_done < target) chk("run_timeout", 64'(jobs_done), 64'(target));
    endtask

    task automatic run_idle(int budget, bit rnd);
        int n = 0;
        while ((m_run || jq.size() > 0) && n < budget) begin rand_step(0, rnd); n++; end
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int   rdy_hi;
        bit   fi, fo;
        logic [1:0] hist;

        // 1: single len-4 job, outputs trail inputs by two cycles
        do_reset();
        step(1, 2'd2, 32'd4, 0, 0, 0);
        rdy_hi = 0; hist = '0;
        for (int c = 0; c < 40 && m_done < 1; c++) begin
            rdy_hi += int'(alu_in_ready);
            fi = m_run && (m_ins < m_len);
            fo = hist[1];
            step(0, 0, 0, fi, fo, 0);
            hist = {hist[0], fi};
        end
        chk("t1_done", 64'(jobs_done), 64'd1);
        chk("t1_last_cycles", 64'(last_cycles), 64'd6);
        chk("t1_config", 64'(alu_config), 64'd2);
        chk("t1_ready_cycles", 64'(rdy_hi), 64'd4);

        // 2: fill the queue behind a stalled job
        do_reset();
        step(1, 2'd0, 32'd3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'(i), 32'd3, 0, 0, 0);
            if (i >= 3) begin
                chk("t2_full_ready", 64'(job_ready), 64'd0);
                chk("t2_full_level", 64'(queue_level), 64'd4);
            end
        end
        run_jobs(1, 40);
        chk("t2_level_after_pop", 64'(queue_level), 64'd3);
        run_idle(200, 0);
        chk("t2_done", 64'(jobs_done), 64'd5);

        // 3: back-to-back jobs switch op with no busy gap
        do_reset();
        step(1, 2'd1, 32'd2, 0, 0, 0);
        step(1, 2'd3, 32'd2, 0, 0, 0);
        run_jobs(1, 40);
        chk("t3_config_switch", 64'(alu_config), 64'd3);
        chk("t3_busy_no_gap", 64'(busy), 64'd1);
        run_jobs(2, 40);

        // 4: zero-length job completes at pop
        do_reset();
        step(1, 2'd1, 32'd0, 0, 0, 0);
        step(1, 2'd2, 32'd1, 0, 0, 0);
        chk("t4_zero_done", 64'(jobs_done), 64'd1);
        chk("t4_zero_busy", 64'(busy), 64'd0);
        run_jobs(2, 40);
        chk("t4_done", 64'(jobs_done), 64'd2);
        chk("t4_last", 64'(last_cycles), 64'd2);

        // 5: spurious output beat in IDLE, then reset mid-job
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        chk("t5_spurious", 64'(spurious), 64'd1);
        chk("t5_done_unchanged", 64'(jobs_done), 64'd0);
        step(1, 2'd3, 32'd5, 0, 0, 0);
        step(1, 2'd1, 32'd2, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("t5_busy_before_rst", 64'(busy), 64'd1);
        do_reset();
        step(0, 0, 0, 0, 0, 0);

`ifdef SNAX_ALU_SCHED_IRQ_EN
        // 6: sticky completion interrupt, set beats clear
        do_reset();
        step(1, 2'd1, 32'd1, 0, 0, 0);
        run_jobs(1, 20);
        chk("t6_irq_set", 64'(irq), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_irq_clr", 64'(irq), 64'd0);
        step(1, 2'd2, 32'd1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("t6_set_wins", 64'(irq), 64'd1);
`endif

        // random traffic against the model
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 50; c++) rand_step(1, 1);
            run_idle(400, 1);
        end
        step(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
